pcs_10g_rx_gearbox: RTL and testbench

Receive gearbox for the 10GBASE-R PCS. It sits between the SerDes RX parallel interface and block synchronization. It accumulates IN_W-bit words into a bit buffer and emits 66-bit blocks: a 2-bit sync header plus a 64-bit scrambled payload. It honours one-bit slip requests from block sync, so block alignment can be searched bit by bit.

---
 rtl/pcs_10g_rx_gearbox.sv | 90 +++++++++
 tb/tb_pcs_10g_rx_gearbox.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_10g_rx_gearbox.sv
// rtl/pcs_10g_rx_gearbox.sv - 10GBASE-R receive gearbox: IN_W-bit words to 66-bit blocks with bit slip
module pcs_10g_rx_gearbox #(
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  input  logic            slip,
  output logic [1:0]      rx_sync_header,
  output logic [63:0]     rx_payload,
  output logic            rx_valid,
  output logic [6:0]      bit_offset,
  output logic [7:0]      buf_level
);

  localparam int BUF_W = 65 + IN_W;

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_s;
  logic [BUF_W-1:0] buf_e;
  logic [BUF_W-1:0] buf_d;
  logic [BUF_W-1:0] in_ext;
  logic [BUF_W-1:0] keep_mask;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_s;
  logic [7:0]       cnt_e;
  logic [7:0]       cnt_d;
  logic             slip_pend_q;
  logic             slip_pend_d;
  logic [6:0]       off_d;
  logic             emit;

  // Slip, then emit, then append: each stage sees the result of the previous one.
  always_comb begin
    buf_s       = buf_q;
    cnt_s       = cnt_q;
    slip_pend_d = slip_pend_q;
    off_d       = bit_offset;
    if (slip || slip_pend_q) begin
      if (cnt_q != 8'd0) begin
        buf_s       = buf_q >> 1;
        cnt_s       = cnt_q - 8'd1;
        slip_pend_d = 1'b0;
        off_d       = (bit_offset == 7'd65) ? 7'd0 : bit_offset + 7'd1;
      end else begin
        slip_pend_d = 1'b1;
      end
    end

    emit  = (cnt_s >= 8'd66);
    buf_e = emit ? (buf_s >> 66) : buf_s;
    cnt_e = emit ? (cnt_s - 8'd66) : cnt_s;

    // Bits above the level are cleared before the new word lands there.
    in_ext    = BUF_W'(in_data) << cnt_e;
    keep_mask = ~({BUF_W{1'b1}} << cnt_e);
    buf_d     = buf_e;
    cnt_d     = cnt_e;
    if (in_valid) begin
      buf_d = (buf_e & keep_mask) | in_ext;
      cnt_d = cnt_e + 8'(IN_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q          <= '0;
      cnt_q          <= 8'd0;
      slip_pend_q    <= 1'b0;
      bit_offset     <= 7'd0;
      rx_valid       <= 1'b0;
      rx_sync_header <= 2'd0;
      rx_payload     <= 64'd0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      slip_pend_q <= slip_pend_d;
      bit_offset  <= off_d;
      rx_valid    <= emit;
      if (emit) begin
        rx_sync_header <= buf_s[1:0];
        rx_payload     <= buf_s[65:2];
      end
    end
  end

  assign buf_level = cnt_q;

endmodule

// File: tb/tb_pcs_10g_rx_gearbox.sv
// tb/tb_pcs_10g_rx_gearbox.sv - directed self-checking bench for pcs_10g_rx_gearbox (IN_W=32)
module tb_pcs_10g_rx_gearbox;

  localparam int IN_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        slip;
  logic [1:0]  rx_sync_header;
  logic [63:0] rx_payload;
  logic        rx_valid;
  logic [6:0]  bit_offset;
  logic [7:0]  buf_level;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic        bsync_en;
  logic [65:0] got[$];
  int          got_cyc[$];
  bit          stream[$];
  logic [31:0] words[$];

  always #5 clk = ~clk;

  pcs_10g_rx_gearbox #(.IN_W(IN_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .slip           (slip),
    .rx_sync_header (rx_sync_header),
    .rx_payload     (rx_payload),
    .rx_valid       (rx_valid),
    .bit_offset     (bit_offset),
    .buf_level      (buf_level)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      got.push_back({rx_payload, rx_sync_header});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bsync_en) slip = rx_valid && (rx_sync_header == 2'b00 || rx_sync_header == 2'b11);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    slip     = 1'b0;
    bsync_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got.delete();
    got_cyc.delete();
    stream.delete();
    words.delete();
    rst_n = 1'b1;
  endtask

  task automatic push_bits(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) stream.push_back(v[i]);
  endtask

  task automatic push_block(input logic [1:0] h, input logic [63:0] p);
    push_bits(2, {62'd0, h});
    push_bits(64, p);
  endtask

  task automatic pack();
    while (stream.size() % IN_W != 0) stream.push_back(1'b0);
    for (int w = 0; w < stream.size() / IN_W; w++) begin
      logic [31:0] v;
      for (int b = 0; b < IN_W; b++) v[b] = stream[w * IN_W + b];
      words.push_back(v);
    end
  endtask

  task automatic send_words(input bit gap, input int s_from, input int s_num);
    for (int i = 0; i < words.size(); i++) begin
      if (gap) begin
        int g = 0;
        while (g < 8 && $urandom_range(0, 1) == 1) begin
          tick();
          g++;
        end
      end
      in_data  = words[i];
      in_valid = 1'b1;
      if (s_num > 0) slip = (i >= s_from) && (i < s_from + s_num);
      tick();
      in_valid = 1'b0;
    end
    if (s_num > 0) slip = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_blocks(input string tag, input int first_got, input int first_blk,
                              input int n, input logic [1:0] h);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_blk%0d", tag, first_blk + k), got[first_got + k],
          {64'(first_blk + k), h});
  endtask

  initial begin
    int win;
    int adj;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    slip     = 1'b0;
    in_data  = 32'd0;
    bsync_en = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      slip     = ~i[0];
      in_data  = 32'hA5A5_0000 + i;
    end
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_hdr", rx_sync_header, 2'd0);
    chk("rst_payload", rx_payload, 64'd0);
    chk("rst_offset", bit_offset, 7'd0);
    chk("rst_level", buf_level, 8'd0);

    // Aligned stream, 48 blocks of header 01.
    do_reset();
    for (int j = 0; j < 48; j++) push_block(2'b01, 64'(j));
    pack();
    send_words(1'b0, 0, 0);
    chk("aligned_count", got.size(), 48);
    check_blocks("aligned", 0, 0, 48, 2'b01);
    chk("first_pulse_edge", got_cyc[0], 4);
    win = 0;
    adj = 0;
    foreach (got_cyc[i]) begin
      if (got_cyc[i] >= 4 && got_cyc[i] <= 36) win++;
      if (i > 0 && got_cyc[i] - got_cyc[i-1] < 2) adj++;
    end
    chk("pulses_per_33", win, 16);
    chk("adjacent_pulses", adj, 0);
    chk("aligned_offset", bit_offset, 7'd0);
    chk("aligned_level", buf_level, 8'd0);

    // 7 junk bits, block sync slips on each bad header.
    do_reset();
    push_bits(7, 64'd0);
    for (int j = 0; j < 48; j++) push_block(2'b10, 64'(j));
    pack();
    bsync_en = 1'b1;
    send_words(1'b0, 0, 0);
    bsync_en = 1'b0;
    slip     = 1'b0;
    chk("misal_count", got.size(), 48);
    check_blocks("misal", 7, 7, 41, 2'b10);
    chk("misal_offset", bit_offset, 7'd7);
    chk("misal_level", buf_level, 8'd25);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hdr", rx_sync_header, 2'd0);
    chk("async_payload", rx_payload, 64'd0);
    chk("async_offset", bit_offset, 7'd0);
    chk("async_level", buf_level, 8'd0);

    // Slip before any data stays pending and drops the first received bit.
    do_reset();
    push_bits(1, 64'd1);
    for (int j = 0; j < 20; j++) push_block(2'b01, 64'(j));
    pack();
    slip = 1'b1;
    tick();
    slip = 1'b0;
    chk("pend_e1_offset", bit_offset, 7'd0);
    chk("pend_e1_level", buf_level, 8'd0);
    in_data  = words.pop_front();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pend_e2_level", buf_level, 8'd32);
    chk("pend_e2_offset", bit_offset, 7'd0);
    tick();
    chk("pend_e3_level", buf_level, 8'd31);
    chk("pend_e3_offset", bit_offset, 7'd1);
    send_words(1'b0, 0, 0);
    chk("pend_count", got.size(), 20);
    check_blocks("pend", 0, 0, 20, 2'b01);

    // Gapped input gives the same blocks.
    do_reset();
    for (int j = 0; j < 48; j++) push_block(2'b01, 64'(j));
    pack();
    send_words(1'b1, 0, 0);
    chk("gap_count", got.size(), 48);
    check_blocks("gap", 0, 0, 48, 2'b01);

    // 66 slips while data flows: offset wraps, one block is lost, tail realigns.
    do_reset();
    for (int j = 0; j < 60; j++) push_block(2'b01, 64'(j));
    pack();
    send_words(1'b0, 20, 66);
    chk("wrap_count", got.size(), 59);
    check_blocks("wrap", 49, 50, 10, 2'b01);
    chk("wrap_offset", bit_offset, 7'd0);
    chk("wrap_level", buf_level, 8'd8);

    // Reset while a slip is pending and data is buffered.
    do_reset();
    slip = 1'b1;
    tick();
    slip     = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("prst_level_before", buf_level, 8'd32);
    #2;
    rst_n = 1'b0;
    #1;
    chk("prst_level", buf_level, 8'd0);
    chk("prst_valid", rx_valid, 1'b0);
    do_reset();
    for (int j = 0; j < 10; j++) push_block(2'b01, 64'(j + 100));
    pack();
    send_words(1'b0, 0, 0);
    chk("prst_count", got.size(), 10);
    check_blocks("prst", 0, 100, 10, 2'b01);
    chk("prst_offset", bit_offset, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
